// File: rtl/fifo_pkg.sv
// Shared constants and pointer helper for the FIFO drain stage.
// Internal buffer is three entries deep, so pointers wrap 2 -> 0.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int BUF_DEPTH      = 3;

    localparam logic [1:0] PTR_LAST = 2'(BUF_DEPTH - 1);
    localparam logic [1:0] OCC_FULL = 2'(BUF_DEPTH);

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == PTR_LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// Three-entry circular buffer that absorbs the FIFO read latency.
// Head entry is always visible on o_head; occupancy tracks stored words.
module fifo_stream_reader_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [1:0]            o_occupancy
);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [1:0]            r_occ;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_occ    <= 2'd0;
        end else begin
            // The issue logic never lets a word arrive into a full buffer
            assert (!(i_push && r_occ == OCC_FULL));
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (i_push && !i_pop) begin
                r_occ <= r_occ + 2'd1;
            end else if (!i_push && i_pop) begin
                r_occ <= r_occ - 2'd1;
            end
        end
    end

    assign o_head      = r_mem[r_rd_ptr];
    assign o_occupancy = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO drain stage: issues reads against buffer credit and presents
// the words as a valid/ready stream with a periodic burst marker.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [1:0]            occupancy
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

    logic          r_active;
    logic          r_inflight;
    logic [CW-1:0] r_beat;

    logic [1:0]    w_occ;
    logic [2:0]    w_credit_used;
    logic          w_read_en;
    logic          w_pop;

    // Credit counts words already held plus the one still in flight
    assign w_credit_used = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_read_en     = r_active && !fifo_empty
                         && (w_credit_used < 3'(BUF_DEPTH));
    assign w_pop         = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_active   <= 1'b0;
            r_inflight <= 1'b0;
            r_beat     <= '0;
        end else begin
            r_active   <= 1'b1;
            r_inflight <= w_read_en;
            if (w_pop) begin
                r_beat <= (r_beat == CNT_LAST) ? '0 : r_beat + 1'b1;
            end
        end
    end

    fifo_stream_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_push      (r_inflight),
        .i_push_data (fifo_data),
        .i_pop       (w_pop),
        .o_head      (out_data),
        .o_occupancy (w_occ)
    );

    assign fifo_read_en = w_read_en;
    assign out_valid    = (w_occ != 2'd0);
    assign out_last     = out_valid && (r_beat == CNT_LAST);
    assign occupancy    = w_occ;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a 1-cycle-latency FIFO model.
// Accepted beats are logged and compared against hand-derived streams.
module tb_fifo_stream_reader;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       fifo_read_en;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic [1:0] occupancy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] q[$];
    logic [7:0] recv[$];
    logic       rlast[$];
    int         rcyc[$];
    int         rdcyc[$];
    logic       rd_sample = 1'b0;

    fifo_stream_reader #(
        .DATA_WIDTH (8),
        .BURST_LEN  (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_read_en (fifo_read_en),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .occupancy    (occupancy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // FIFO model: data appears just after the edge that saw read_en
    always begin
        @(posedge clock);
        #1;
        if (rd_sample && q.size() > 0) begin
            fifo_data = q.pop_front();
        end
        fifo_empty = (q.size() == 0);
    end

    always @(negedge clock) begin
        rd_sample = fifo_read_en;
        if (reset_n) begin
            if (fifo_read_en) rdcyc.push_back(cyc);
            if (out_valid && out_ready) begin
                recv.push_back(out_data);
                rlast.push_back(out_last);
                rcyc.push_back(cyc);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_beats(input int n);
        int k;
        k = 0;
        while (recv.size() < n && k < 200) begin
            step();
            k++;
        end
    endtask

    initial begin
        int b;
        int rb;
        int k;

        // 1: reset holds read_en low even with a non-empty FIFO
        reset_n = 1'b0;
        q.push_back(8'hAA);
        step(2);
        chk("rst_fifo_empty", 32'(fifo_empty), 32'd0);
        chk("rst_read_en", 32'(fifo_read_en), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        q.delete();
        step(2);
        reset_n = 1'b1;
        step(2);
        chk("idle_valid", 32'(out_valid), 32'd0);

        // 2: full-rate stream of 8 words
        b = recv.size();
        rb = rdcyc.size();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) q.push_back(8'(i));
        wait_beats(b + 8);
        step(3);
        chk("t2_count", 32'(recv.size() - b), 32'd8);
        chk("t2_reads", 32'(rdcyc.size() - rb), 32'd8);
        if (recv.size() >= b + 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t2_data%0d", i), 32'(recv[b+i]), 32'(i + 1));
                chk($sformatf("t2_last%0d", i), 32'(rlast[b+i]),
                    32'((i % 4) == 3));
            end
            chk("t2_latency", 32'(rcyc[b] - rdcyc[rb]), 32'd2);
            chk("t2_rate", 32'(rcyc[b+7] - rcyc[b]), 32'd7);
        end

        // 3: backpressure fills the buffer, then drains in order
        out_ready = 1'b0;
        b = recv.size();
        rb = rdcyc.size();
        for (int i = 0; i < 10; i++) q.push_back(8'(8'h10 + i));
        step(10);
        chk("t3_reads", 32'(rdcyc.size() - rb), 32'd3);
        chk("t3_occ", 32'(occupancy), 32'd3);
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_head", 32'(out_data), 32'h10);
        chk("t3_read_en", 32'(fifo_read_en), 32'd0);
        step(5);
        chk("t3_reads_hold", 32'(rdcyc.size() - rb), 32'd3);
        chk("t3_head_hold", 32'(out_data), 32'h10);
        out_ready = 1'b1;
        wait_beats(b + 10);
        step(3);
        chk("t3_count", 32'(recv.size() - b), 32'd10);
        if (recv.size() >= b + 10) begin
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("t3_data%0d", i), 32'(recv[b+i]),
                    32'(8'h10 + i));
            end
        end

        // 4: FIFO drains to empty while the last read is in flight
        b = recv.size();
        rb = rdcyc.size();
        q.push_back(8'h55);
        wait_beats(b + 1);
        step(4);
        chk("t4_count", 32'(recv.size() - b), 32'd1);
        if (recv.size() >= b + 1) chk("t4_data", 32'(recv[b]), 32'h55);
        chk("t4_reads", 32'(rdcyc.size() - rb), 32'd1);
        chk("t4_read_en", 32'(fifo_read_en), 32'd0);
        chk("t4_occ", 32'(occupancy), 32'd0);

        // 5: ready toggles each cycle; 19 beats accepted since reset
        b = recv.size();
        for (int i = 0; i < 16; i++) q.push_back(8'(8'h20 + i));
        k = 0;
        while (recv.size() < b + 16 && k < 200) begin
            out_ready = ~out_ready;
            step();
            k++;
        end
        out_ready = 1'b1;
        step(4);
        chk("t5_count", 32'(recv.size() - b), 32'd16);
        if (recv.size() >= b + 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("t5_data%0d", i), 32'(recv[b+i]),
                    32'(8'h20 + i));
                chk($sformatf("t5_last%0d", i), 32'(rlast[b+i]),
                    32'(((19 + i) % 4) == 3));
            end
        end

        // 6: async reset with two words buffered and one in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) q.push_back(8'(8'h60 + i));
        k = 0;
        while (occupancy != 2'd2 && k < 20) begin
            step();
            k++;
        end
        chk("t6_occ_pre", 32'(occupancy), 32'd2);
        chk("t6_rd_pre", 32'(fifo_read_en), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_occ", 32'(occupancy), 32'd0);
        chk("t6_data", 32'(out_data), 32'd0);
        chk("t6_last", 32'(out_last), 32'd0);
        chk("t6_read_en", 32'(fifo_read_en), 32'd0);
        q.delete();
        step(2);
        reset_n = 1'b1;
        step(2);
        b = recv.size();
        out_ready = 1'b1;
        q.push_back(8'h77);
        q.push_back(8'h78);
        wait_beats(b + 2);
        step(3);
        chk("t6_count", 32'(recv.size() - b), 32'd2);
        if (recv.size() >= b + 2) begin
            chk("t6_first", 32'(recv[b]), 32'h77);
            chk("t6_second", 32'(recv[b+1]), 32'h78);
            chk("t6_first_last", 32'(rlast[b]), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
